qft_phase_sched: RTL and testbench

- Sequencer that applies one controlled-phase gate R_k to a 2^NQ-entry amplitude vector.
- Walks every amplitude index in order and reads each amplitude from the amplitude RAM.
- When the control and target bits of the index are both 1, it drives the external complex multiplier with the twiddle factor (cos, sin of 2*pi/2^k). Otherwise the amplitude passes through, rescaled.
- Emits one result per index on a valid/ready stream toward the next QFT stage.

---
 rtl/qft_pkg.sv | 37 +++
 rtl/qft_twiddle_rom.sv | 35 +++
 rtl/qft_phase_sched.sv | 197 +++++++++++++++++++
 tb/tb_qft_phase_sched.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qft_pkg.sv
// ============================================================================
// Module      : qft_pkg
// Description : Shared widths, FSM state type and Q1.10 twiddle table for the
//               QFT controlled-phase sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package qft_pkg;

  localparam int AMP_W      = 8;
  localparam int TW_W       = 12;
  localparam int RES_W      = 13;
  localparam int FRAC_SHIFT = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_CALC  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Entry n holds the twiddle for rotation order k = n+1.
  localparam logic signed [TW_W-1:0] TW_COS [8] = '{
    -12'sd1024, 12'sd0, 12'sd724, 12'sd946,
    12'sd1004, 12'sd1019, 12'sd1023, 12'sd1024
  };

  localparam logic signed [TW_W-1:0] TW_SIN [8] = '{
    12'sd0, 12'sd1024, 12'sd724, 12'sd392,
    12'sd200, 12'sd100, 12'sd50, 12'sd25
  };

endpackage

`default_nettype wire

// File: rtl/qft_twiddle_rom.sv
// ============================================================================
// Module      : qft_twiddle_rom
// Description : Combinational rotation-order to (cos, sin) lookup; orders
//               outside 1..8 return the identity twiddle (1024, 0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qft_twiddle_rom
  import qft_pkg::*;
(
  input  logic        [3:0]      i_k,
  output logic signed [TW_W-1:0] o_cos,
  output logic signed [TW_W-1:0] o_sin
);

  logic       w_k_ok;
  logic [2:0] w_sel;

  assign w_k_ok = (i_k >= 4'd1) && (i_k <= 4'd8);
  // k=8 wraps to 0 in three bits, so subtracting one lands on entry 7.
  assign w_sel  = i_k[2:0] - 3'd1;

  always_comb begin
    o_cos = 12'sd1024;
    o_sin = 12'sd0;
    if (w_k_ok) begin
      o_cos = TW_COS[w_sel];
      o_sin = TW_SIN[w_sel];
    end
  end

endmodule

`default_nettype wire

// File: rtl/qft_phase_sched.sv
// ============================================================================
// Module      : qft_phase_sched
// Description : Applies one controlled-phase gate R_k across a 2^NQ amplitude
//               vector, one result per index on a valid/ready stream.
//               Optional conjugate twiddle via macro QFT_INVERSE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qft_phase_sched
  import qft_pkg::*;
#(
  parameter int NQ = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic        [2:0]       cfg_ctrl,
  input  logic        [2:0]       cfg_tgt,
  input  logic        [3:0]       cfg_k,
`ifdef QFT_INVERSE_EN
  input  logic                    cfg_inv,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    mem_rd_en,
  output logic        [NQ-1:0]    mem_addr,
  input  logic signed [AMP_W-1:0] mem_rd_r,
  input  logic signed [AMP_W-1:0] mem_rd_i,
  output logic signed [AMP_W-1:0] mul_in_r,
  output logic signed [AMP_W-1:0] mul_in_i,
  output logic signed [TW_W-1:0]  mul_cos,
  output logic signed [TW_W-1:0]  mul_sin,
  input  logic signed [RES_W-1:0] mul_out_r,
  input  logic signed [RES_W-1:0] mul_out_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic        [NQ-1:0]    out_addr,
  output logic signed [RES_W-1:0] out_r,
  output logic signed [RES_W-1:0] out_i
);

  localparam logic [3:0] c_nq = 4'(NQ);

  state_t                  r_state;
  logic        [NQ-1:0]    r_idx;
  logic        [2:0]       r_ctrl;
  logic        [2:0]       r_tgt;
  logic        [3:0]       r_k;
  logic                    r_inv;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;
  logic                    r_rd_en;
  logic        [NQ-1:0]    r_mem_addr;
  logic                    r_out_valid;
  logic        [NQ-1:0]    r_out_addr;
  logic signed [RES_W-1:0] r_out_r;
  logic signed [RES_W-1:0] r_out_i;

  logic                    w_cfg_ok;
  logic                    w_inv_in;
  logic        [7:0]       w_idx_x;
  logic                    w_rot;
  logic                    w_rot_calc;
  logic signed [TW_W-1:0]  w_rom_cos;
  logic signed [TW_W-1:0]  w_rom_sin;
  logic signed [TW_W-1:0]  w_sin_sel;
  logic signed [RES_W-1:0] w_pass_r;
  logic signed [RES_W-1:0] w_pass_i;
  logic signed [RES_W-1:0] w_res_r;
  logic signed [RES_W-1:0] w_res_i;
  logic        [NQ-1:0]    w_idx_nxt;

  assign w_cfg_ok = ({1'b0, cfg_ctrl} < c_nq) && ({1'b0, cfg_tgt} < c_nq) &&
                    (cfg_k >= 4'd1) && (cfg_k <= 4'd8);

`ifdef QFT_INVERSE_EN
  assign w_inv_in  = cfg_inv;
  assign w_sin_sel = r_inv ? -w_rom_sin : w_rom_sin;
`else
  assign w_inv_in  = 1'b0;
  assign w_sin_sel = w_rom_sin;
`endif

  // Zero-extend so the 3-bit qubit selects always address a legal bit.
  assign w_idx_x    = 8'(r_idx);
  assign w_rot      = w_idx_x[r_ctrl] & w_idx_x[r_tgt];
  assign w_rot_calc = (r_state == ST_CALC) && w_rot;
  assign w_idx_nxt  = r_idx + NQ'(1);

  qft_twiddle_rom u_rom (
    .i_k   (r_k),
    .o_cos (w_rom_cos),
    .o_sin (w_rom_sin)
  );

  // The multiplier is combinational, so its operands live only in CALC.
  assign mul_in_r = w_rot_calc ? mem_rd_r  : '0;
  assign mul_in_i = w_rot_calc ? mem_rd_i  : '0;
  assign mul_cos  = w_rot_calc ? w_rom_cos : '0;
  assign mul_sin  = w_rot_calc ? w_sin_sel : '0;

  assign w_pass_r = RES_W'(mem_rd_r) <<< FRAC_SHIFT;
  assign w_pass_i = RES_W'(mem_rd_i) <<< FRAC_SHIFT;
  assign w_res_r  = w_rot ? mul_out_r : w_pass_r;
  assign w_res_i  = w_rot ? mul_out_i : w_pass_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_ctrl      <= '0;
      r_tgt       <= '0;
      r_k         <= '0;
      r_inv       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rd_en     <= 1'b0;
      r_mem_addr  <= '0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_r     <= '0;
      r_out_i     <= '0;
    end else begin
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (!w_cfg_ok) begin
              r_err <= 1'b1;
            end else begin
              r_ctrl     <= cfg_ctrl;
              r_tgt      <= cfg_tgt;
              r_k        <= cfg_k;
              r_inv      <= w_inv_in;
              r_idx      <= '0;
              r_busy     <= 1'b1;
              r_rd_en    <= 1'b1;
              r_mem_addr <= '0;
              r_state    <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          r_state <= ST_CALC;
        end
        ST_CALC: begin
          r_out_r     <= w_res_r;
          r_out_i     <= w_res_i;
          r_out_addr  <= r_idx;
          r_out_valid <= 1'b1;
          r_state     <= ST_EMIT;
        end
        ST_EMIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_idx == '1) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_idx      <= w_idx_nxt;
              r_rd_en    <= 1'b1;
              r_mem_addr <= w_idx_nxt;
              r_state    <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign mem_rd_en = r_rd_en;
  assign mem_addr  = r_mem_addr;
  assign out_valid = r_out_valid;
  assign out_addr  = r_out_addr;
  assign out_r     = r_out_r;
  assign out_i     = r_out_i;

endmodule

`default_nettype wire

// File: tb/tb_qft_phase_sched.sv
// ============================================================================
// Module      : tb_qft_phase_sched
// Description : Directed self-checking bench for qft_phase_sched (NQ=2) with a
//               registered-read RAM model and a combinational multiplier model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qft_phase_sched;

  localparam int NQ = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic        [2:0]  cfg_ctrl;
  logic        [2:0]  cfg_tgt;
  logic        [3:0]  cfg_k;
`ifdef QFT_INVERSE_EN
  logic               cfg_inv;
`endif
  logic               busy, done, err, mem_rd_en, out_valid, out_ready;
  logic      [NQ-1:0] mem_addr, out_addr;
  logic signed [7:0]  mem_rd_r, mem_rd_i, mul_in_r, mul_in_i;
  logic signed [11:0] mul_cos, mul_sin;
  logic signed [12:0] mul_out_r, mul_out_i, out_r, out_i;

  logic signed [7:0]  ram_r [4];
  logic signed [7:0]  ram_i [4];

  int n_total = 0;
  int n_bad   = 0;
  int res_a [8];
  int res_r [8];
  int res_i [8];
  int n_res, done_c, cap_sin;

  always #5 clk = ~clk;

  qft_phase_sched #(.NQ(NQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_ctrl  (cfg_ctrl),
    .cfg_tgt   (cfg_tgt),
    .cfg_k     (cfg_k),
`ifdef QFT_INVERSE_EN
    .cfg_inv   (cfg_inv),
`endif
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rd_r  (mem_rd_r),
    .mem_rd_i  (mem_rd_i),
    .mul_in_r  (mul_in_r),
    .mul_in_i  (mul_in_i),
    .mul_cos   (mul_cos),
    .mul_sin   (mul_sin),
    .mul_out_r (mul_out_r),
    .mul_out_i (mul_out_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_r     (out_r),
    .out_i     (out_i)
  );

  // RAM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_r <= ram_r[mem_addr];
      mem_rd_i <= ram_i[mem_addr];
    end
  end

  // Complex multiply, integer x Q1.10 -> Q7.5.
  assign mul_out_r = 13'((int'(mul_in_r) * int'(mul_cos) - int'(mul_in_i) * int'(mul_sin)) >>> 5);
  assign mul_out_i = 13'((int'(mul_in_r) * int'(mul_sin) + int'(mul_in_i) * int'(mul_cos)) >>> 5);

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string pre);
    check({pre, "_ctl"}, int'({busy, done, err, mem_rd_en, out_valid, mem_addr, out_addr}), 0);
    check({pre, "_out_r"}, int'(out_r), 0);
    check({pre, "_out_i"}, int'(out_i), 0);
    check({pre, "_mul"}, int'(mul_in_r) | int'(mul_in_i) | int'(mul_cos) | int'(mul_sin), 0);
  endtask

  task automatic load_ram(input int r0, i0, r1, i1, r2, i2, r3, i3);
    ram_r[0] = 8'(r0); ram_i[0] = 8'(i0);
    ram_r[1] = 8'(r1); ram_i[1] = 8'(i1);
    ram_r[2] = 8'(r2); ram_i[2] = 8'(i2);
    ram_r[3] = 8'(r3); ram_i[3] = 8'(i3);
  endtask

  // Pulses start, then gathers handshakes until done; done_c=-1 on timeout.
  task automatic run(input logic [2:0] c, input logic [2:0] t, input logic [3:0] k,
                     input int restart_at);
    cfg_ctrl = c; cfg_tgt = t; cfg_k = k;
    n_res = 0; done_c = -1; cap_sin = 0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_at);
      if (out_valid && out_ready && n_res < 8) begin
        res_a[n_res] = int'(out_addr);
        res_r[n_res] = int'(out_r);
        res_i[n_res] = int'(out_i);
        n_res++;
      end
      if (mul_sin != 0) cap_sin = int'(mul_sin);
      if (done) begin
        done_c = cyc;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int found, bad, hold_r, hold_i, seen;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    cfg_ctrl = '0; cfg_tgt = '0; cfg_k = '0;
`ifdef QFT_INVERSE_EN
    cfg_inv = 1'b0;
`endif
    load_ram(7, -2, 1, 1, 2, 0, 5, 3);
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // k=2, ctrl=0, tgt=1: only index 3 rotates by +i.
    run(3'd0, 3'd1, 4'd2, 0);
    check("k2_count", n_res, 4);
    check("k2_a0", res_a[0], 0); check("k2_r0", res_r[0], 224); check("k2_i0", res_i[0], -64);
    check("k2_a1", res_a[1], 1); check("k2_r1", res_r[1], 32);  check("k2_i1", res_i[1], 32);
    check("k2_a2", res_a[2], 2); check("k2_r2", res_r[2], 64);  check("k2_i2", res_i[2], 0);
    check("k2_a3", res_a[3], 3); check("k2_r3", res_r[3], -96); check("k2_i3", res_i[3], 160);
    check("k2_done_cyc", done_c, 13);
    check("k2_sin", cap_sin, 1024);
    @(negedge clk);
    check("k2_busy_after", int'(busy), 0);

    // k=1 single-qubit gate on qubit 0: odd indices negate.
    load_ram(3, -1, 4, 0, -2, 5, 1, 2);
    run(3'd0, 3'd0, 4'd1, 0);
    check("k1_count", n_res, 4);
    check("k1_r0", res_r[0], 96);
    check("k1_r1", res_r[1], -128); check("k1_i1", res_i[1], 0);
    check("k1_i2", res_i[2], 160);
    check("k1_r3", res_r[3], -32);  check("k1_i3", res_i[3], -64);
    check("k1_done_cyc", done_c, 13);
    @(negedge clk);

    // Invalid configurations.
    for (int v = 0; v < 2; v++) begin
      cfg_ctrl = 3'd0;
      cfg_tgt  = (v == 0) ? 3'd1 : 3'(NQ);
      cfg_k    = (v == 0) ? 4'd0 : 4'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("inv_err_hi", int'(err), 1);
      check("inv_busy", int'(busy), 0);
      seen = int'(mem_rd_en);
      @(negedge clk);
      check("inv_err_lo", int'(err), 0);
      repeat (4) begin
        seen = seen | int'(mem_rd_en) | int'(busy);
        @(negedge clk);
      end
      check("inv_no_rd", seen, 0);
    end

    // Backpressure on index 1.
    load_ram(7, -2, 1, 1, 2, 0, 5, 3);
    cfg_ctrl = 3'd0; cfg_tgt = 3'd1; cfg_k = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (out_valid && out_addr == 2'd1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("bp_reach", found, 1);
    hold_r = int'(out_r); hold_i = int'(out_i);
    check("bp_data_r", hold_r, 32);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!out_valid || out_addr != 2'd1 || int'(out_r) != hold_r ||
          int'(out_i) != hold_i || mem_rd_en) bad++;
    end
    check("bp_hold", bad, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_resume_rd", int'(mem_rd_en), 1);
    check("bp_resume_addr", int'(mem_addr), 2);
    found = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (done) begin
        found = 1;
        break;
      end
    end
    check("bp_done", found, 1);
    @(negedge clk);

    // Asynchronous reset during CALC of index 2.
    cfg_ctrl = 3'd0; cfg_tgt = 3'd1; cfg_k = 4'd2;
    start = 1'b1;
    found = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_rd_en && mem_addr == 2'd2) begin
        found = 1;
        break;
      end
    end
    check("rst_reach", found, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(3'd0, 3'd1, 4'd2, 4);
    check("rst_count", n_res, 4);
    bad = 0;
    for (int i = 0; i < 4; i++) if (res_a[i] != i) bad++;
    check("rst_order", bad, 0);
    check("rst_r0", res_r[0], 224);
    check("rst_r3", res_r[3], -96);
    check("rst_done_cyc", done_c, 13);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | int'(mem_rd_en) | int'(busy);
    end
    check("rst_idle_after", seen, 0);

`ifdef QFT_INVERSE_EN
    cfg_inv = 1'b1;
    run(3'd0, 3'd1, 4'd2, 0);
    cfg_inv = 1'b0;
    check("inv_sin", cap_sin, -1024);
    check("inv_r3", res_r[3], 96);
    check("inv_i3", res_i[3], -160);
    check("inv_r0", res_r[0], 224);
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
